upstream_request_arbiter: RTL
=============================

UPSTREAM_REQUEST_ARBITER -- requirements
Module: upstream_request_arbiter

Interface
REQ-001 Parameters SHALL be: NUM_REQ, default 4, number of requester ports; PROC_LAT, default 2, processor cycles from a presented client_id or issue pulse to valid outputs.
REQ-002 Ports SHALL be:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-port request valid.
- req_ready  out  NUM_REQ  per-port accept; at most one bit high.
- req_op  in  NUM_REQ  per-port opcode: 0 = order, 1 = max update.
- req_client_id  in  NUM_REQ*5  packed client ids.
- req_amount  in  NUM_REQ*32  packed amounts.
- rsp_valid  out  NUM_REQ  one-hot, one-cycle response strobe.
- rsp_reject  out  1  order refused by the risk check.
- rsp_accumulated  out  32  accumulated orders after the operation.
- rsp_max  out  32  max_to_trade after the operation.
- up_client_id  out  5  client id to the upstream processor.
- up_amount  out  32  amount to the upstream processor.
- up_new_order  out  1  one-cycle order pulse.
- up_new_max  out  1  one-cycle max-update pulse.
- up_accumulated_orders  in  32  processor accumulated total.
- up_max_to_trade  in  32  processor max.
- busy  out  1  high in any state other than IDLE.

Function
REQ-003 The FSM SHALL have the states IDLE, LOOKUP, ISSUE, WAIT and RESP.
REQ-004 In IDLE with any req_valid high, the arbiter SHALL grant round-robin, starting after the last granted port. It SHALL assert that port's req_ready for that one cycle, latch op/client_id/amount, and go to LOOKUP.
REQ-005 A port SHALL hold its request until it sees req_ready. A request withdrawn before that SHALL NOT be served.
REQ-006 up_client_id and up_amount SHALL come from the latched request in every non-IDLE state.
REQ-007 LOOKUP SHALL last exactly PROC_LAT cycles, then go to ISSUE.
REQ-008 ISSUE SHALL last one cycle and pulse exactly one of up_new_order or up_new_max, selected by the latched op. It then goes to WAIT.
REQ-009 WAIT SHALL last PROC_LAT+1 cycles, then go to RESP.
REQ-010 RESP SHALL last one cycle: granted rsp_valid bit high, rsp_accumulated and rsp_max equal to the current up_* inputs. It returns to IDLE.
REQ-011 Request acceptance to rsp_valid SHALL be a fixed 2*PROC_LAT+3 cycles for issued operations.
REQ-012 up_new_order and up_new_max SHALL never be high at the same time, and SHALL be low outside ISSUE.
REQ-013 Only one request SHALL be in flight. req_ready SHALL be all zeros whenever busy is high.
REQ-014 Max updates SHALL never be rejected.
REQ-015 A port that is granted SHALL become lowest priority on the next arbitration.

Reset
REQ-016 With rst high at a clock edge, the following SHALL hold the next cycle:
- state = IDLE;
- round-robin pointer = NUM_REQ-1, so port 0 has first priority;
- all outputs = 0.
REQ-017 Reset in any state SHALL abort the in-flight request: no response and no further up_* pulse.

Configuration
REQ-018 With UPSTREAM_ARB_RISK_CHECK_EN defined, the risk check SHALL be active:
- At the end of LOOKUP for an order, compare the 33-bit sum up_accumulated_orders + amount against up_max_to_trade.
- If the sum is greater, skip ISSUE and WAIT, and go to RESP with rsp_reject = 1 and the unchanged values.
- A carry out of the 32-bit sum SHALL count as greater.
REQ-019 Without UPSTREAM_ARB_RISK_CHECK_EN, every order SHALL be issued and rsp_reject SHALL be tied to 0.

Structure
REQ-020 A shared package upstream_pkg SHALL hold:
- CLIENT_ID_W = 5 and AMOUNT_W = 32;
- the opcode enum (OP_ORDER, OP_MAX);
- the FSM state enum.
REQ-021 The round-robin grant logic SHALL be a sub-module named rr_arbiter, parameterised by NUM_REQ.

Verification
REQ-022 Max update: port 0 sends max 0xB0C5 for client 0x1B -> up_new_max is pulsed once; the response has rsp_max = 0xB0C5 and rsp_reject = 0.
REQ-023 Order under the limit: port 1 then sends order 0x5C5 for client 0x1B -> up_new_order is pulsed once; rsp_accumulated = 0x5C5 after 2*PROC_LAT+3 cycles.
REQ-024 Order over the limit (RISK_CHECK_EN): port 2 sends order 0xB000 for client 0x1B -> no up_new_order pulse; rsp_reject = 1 and rsp_accumulated = 0x5C5.
REQ-025 Fairness: all four ports hold valid from reset -> grant order 0,1,2,3,0; exactly one req_ready per accepted request.
REQ-026 Reset mid-operation: rst asserted during WAIT -> the next cycle has busy = 0 and rsp_valid = 0; the next grant goes to port 0.
REQ-027 Overflow: client max 0xFFFFFFFF, accumulated 0xFFFFFFF0, order 0x20 -> reject with the check enabled; issued with it disabled.

Source files
------------

// File: rtl/upstream_pkg.sv
// Shared types for the upstream request arbiter: field widths, opcode and FSM state enums,
// the latched request record and the risk-limit comparison.
package upstream_pkg;

  localparam int CLIENT_ID_W = 5;
  localparam int AMOUNT_W    = 32;

  typedef enum logic {
    OP_ORDER = 1'b0,
    OP_MAX   = 1'b1
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_e;

  typedef struct packed {
    op_e                    op;
    logic [CLIENT_ID_W-1:0] client_id;
    logic [AMOUNT_W-1:0]    amount;
  } req_t;

  // 33-bit sum so a carry out of the 32-bit total always counts as over the limit.
  function automatic logic exceeds_limit(input logic [AMOUNT_W-1:0] accumulated,
                                         input logic [AMOUNT_W-1:0] amount,
                                         input logic [AMOUNT_W-1:0] limit);
    logic [AMOUNT_W:0] sum;
    sum = {1'b0, accumulated} + {1'b0, amount};
    return sum > {1'b0, limit};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: combinational one-hot grant searching from the port after the last winner.
// Pointer moves to the winner when advance is high; reset points at the last port so port 0 leads.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx;
  logic             found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = IDX_W'((int'(ptr_q) + i) % NUM_REQ);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
    ptr_d = (advance && found) ? grant_idx : ptr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= IDX_W'(NUM_REQ - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/upstream_request_arbiter.sv
// Serialises per-port order / max-update requests to one upstream processor, one in flight;
// response 2*PROC_LAT+3 cycles after acceptance; optional risk check via UPSTREAM_ARB_RISK_CHECK_EN.
module upstream_request_arbiter
  import upstream_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int PROC_LAT = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ-1:0]          req_op,
  input  logic [NUM_REQ*CLIENT_ID_W-1:0] req_client_id,
  input  logic [NUM_REQ*AMOUNT_W-1:0] req_amount,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic                        rsp_reject,
  output logic [AMOUNT_W-1:0]         rsp_accumulated,
  output logic [AMOUNT_W-1:0]         rsp_max,
  output logic [CLIENT_ID_W-1:0]      up_client_id,
  output logic [AMOUNT_W-1:0]         up_amount,
  output logic                        up_new_order,
  output logic                        up_new_max,
  input  logic [AMOUNT_W-1:0]         up_accumulated_orders,
  input  logic [AMOUNT_W-1:0]         up_max_to_trade,
  output logic                        busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(PROC_LAT + 2);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  req_t                 lat_q, lat_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [NUM_REQ-1:0]   arb_grant;
  logic [IDX_W-1:0]     arb_idx;
  logic                 accept;
  logic [CLIENT_ID_W-1:0] cid_arr [NUM_REQ];
  logic [AMOUNT_W-1:0]    amt_arr [NUM_REQ];
`ifdef UPSTREAM_ARB_RISK_CHECK_EN
  logic                 reject_q, reject_d;
`endif

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign cid_arr[g] = req_client_id[g*CLIENT_ID_W +: CLIENT_ID_W];
    assign amt_arr[g] = req_amount[g*AMOUNT_W +: AMOUNT_W];
  end

  assign accept = (state_q == ST_IDLE) && (|req_valid);
  assign busy   = (state_q != ST_IDLE);

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid),
    .advance   (accept),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    lat_d           = lat_q;
    gnt_d           = gnt_q;
`ifdef UPSTREAM_ARB_RISK_CHECK_EN
    reject_d        = reject_q;
`endif
    req_ready       = '0;
    rsp_valid       = '0;
    rsp_accumulated = '0;
    rsp_max         = '0;
    up_new_order    = 1'b0;
    up_new_max      = 1'b0;
    up_client_id    = '0;
    up_amount       = '0;
    if (state_q != ST_IDLE) begin
      up_client_id = lat_q.client_id;
      up_amount    = lat_q.amount;
    end
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          req_ready       = arb_grant;
          gnt_d           = arb_grant;
          lat_d.op        = op_e'(req_op[arb_idx]);
          lat_d.client_id = cid_arr[arb_idx];
          lat_d.amount    = amt_arr[arb_idx];
          cnt_d           = '0;
`ifdef UPSTREAM_ARB_RISK_CHECK_EN
          reject_d        = 1'b0;
`endif
          state_d         = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (cnt_q == CNT_W'(PROC_LAT - 1)) begin
          cnt_d   = '0;
          state_d = ST_ISSUE;
`ifdef UPSTREAM_ARB_RISK_CHECK_EN
          // Processor outputs for this client are valid on the last lookup cycle.
          if (lat_q.op == OP_ORDER &&
              exceeds_limit(up_accumulated_orders, lat_q.amount, up_max_to_trade)) begin
            reject_d = 1'b1;
            state_d  = ST_RESP;
          end
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_ISSUE: begin
        up_new_order = (lat_q.op == OP_ORDER);
        up_new_max   = (lat_q.op == OP_MAX);
        cnt_d        = '0;
        state_d      = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == CNT_W'(PROC_LAT)) begin
          cnt_d   = '0;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        rsp_valid       = gnt_q;
        rsp_accumulated = up_accumulated_orders;
        rsp_max         = up_max_to_trade;
        state_d         = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef UPSTREAM_ARB_RISK_CHECK_EN
  assign rsp_reject = (state_q == ST_RESP) && reject_q;
`else
  assign rsp_reject = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      lat_q    <= '0;
      gnt_q    <= '0;
`ifdef UPSTREAM_ARB_RISK_CHECK_EN
      reject_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lat_q    <= lat_d;
      gnt_q    <= gnt_d;
`ifdef UPSTREAM_ARB_RISK_CHECK_EN
      reject_q <= reject_d;
`endif
    end
  end

endmodule
